// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
// The leading-zero helper exists only when SEG7_LZB_EN is defined.
package seg7_pkg;

  typedef logic [1:0] idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam idx_t       IDX_LAST  = 2'd3;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [3:0] an_select(input idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

`ifdef SEG7_LZB_EN
  // A slot is dark when it and every more-significant digit are zero.
  // Digit 0 always lights so a value of zero still shows "0".
  function automatic logic lzb_dark(input logic [15:0] value, input idx_t idx);
    logic dark;
    dark = 1'b0;
    case (idx)
      2'd3:    dark = (value[15:12] == 4'd0);
      2'd2:    dark = (value[15:8]  == 8'd0);
      2'd1:    dark = (value[15:4]  == 12'd0);
      default: dark = 1'b0;
    endcase
    return dark;
  endfunction
`endif

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between a BCD value source and the scan controller.
interface seg7_scan_ctrl_if;

  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/bcd2seg.sv
// Combinational BCD to seven-segment decoder, {a,b,c,d,e,f,g}, active-high.
// Non-BCD codes show a dash; callers that want them dark must mask.
module bcd2seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000001;
    case (bcd)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment driver with a frame-synchronous
// shadow load. Define SEG7_LZB_EN to compile in leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg7_scan_ctrl_if.slave        load_if,
  input  logic                   disp_en,
  output logic [3:0]             an_n,
  output logic [6:0]             seg_7
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q,  presc_d;
  idx_t          idx_q,    idx_d;
  logic [15:0]   disp_q,   disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q,   pend_d;
  logic [3:0]    an_n_q,   an_n_d;
  logic [6:0]    seg_q,    seg_d;

  logic          slot_tick;
  logic          frame_tick;
  logic          xfer;
  logic          lz_dark;
  logic [3:0]    digit_sel;
  logic [6:0]    dec_seg;
  logic [3:0]    digit_w [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_w[gi] = disp_q[4*gi +: 4];
  end

  assign slot_tick  = (presc_q == PRESC_LAST);
  assign frame_tick = slot_tick && (idx_q == IDX_LAST);
  assign xfer       = load_if.load_valid && !pend_q;
  assign digit_sel  = digit_w[idx_q];

  assign load_if.load_ready = ~pend_q;

`ifdef SEG7_LZB_EN
  assign lz_dark = lzb_dark(disp_q, idx_q);
`else
  assign lz_dark = 1'b0;
`endif

  bcd2seg u_bcd2seg (
    .bcd (digit_sel),
    .seg (dec_seg)
  );

  always_comb begin
    presc_d  = slot_tick ? '0 : presc_q + 1'b1;
    idx_d    = slot_tick ? idx_t'(idx_q + 2'd1) : idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    an_n_d   = AN_OFF;
    seg_d    = SEG_BLANK;

    // Only a whole frame ever shows one value; new data waits for the wrap.
    if (frame_tick && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end

    // Cannot collide with the apply above: a transfer needs pend_q low.
    if (xfer) begin
      shadow_d = load_if.load_data;
      pend_d   = 1'b1;
    end

    if (disp_en && !lz_dark) begin
      an_n_d = an_select(idx_q);
      if (digit_sel <= BCD_MAX) begin
        seg_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      an_n_q   <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_n_q   <= an_n_d;
      seg_q    <= seg_d;
    end
  end

  assign an_n  = an_n_q;
  assign seg_7 = seg_q;

endmodule
